// File: rtl/game_pkg.sv
// Shared types and constants for the game screen sequencer.
package game_pkg;

   typedef enum logic [2:0] {
      ST_TITLE     = 3'd0,
      ST_PLAY      = 3'd1,
      ST_LOSE      = 3'd2,
      ST_WIN       = 3'd3,
      ST_ISSUE     = 3'd4,
      ST_WAIT_DONE = 3'd5
   } state_e;

   localparam logic [3:0] SCR_START  = 4'd0;
   localparam logic [3:0] SCR_LOSE   = 4'd13;
   localparam logic [3:0] SCR_WIN    = 4'd14;
   localparam logic [1:0] LIVES_INIT = 2'd3;
   localparam logic [2:0] NUM_LEVELS = 3'd4;

   // In-play screen code: 3*level + 1 - lives (1..12 for legal level/lives).
   function automatic logic [3:0] play_screen(input logic [2:0] lv, input logic [1:0] lf);
      logic [4:0] code;
      code = 5'(lv) * 5'd3 + 5'd1 - 5'(lf);
      return code[3:0];
   endfunction

endpackage

// File: rtl/event_latch.sv
// Optional rising-edge detect plus a one-deep pending flag for one event input.
// evt_out is the live event OR'd with the pending one; the owner decides when
// to consume (take) or discard (drop) it, and when a live event may be held (arm).
module event_latch
   import game_pkg::*;
#(
   parameter bit EDGE_DETECT = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic evt_in,
   input  logic arm,
   input  logic take,
   input  logic drop,
   output logic evt_out
);

   logic prev_q, prev_d;
   logic pend_q, pend_d;
   logic live;

   // Live event: a level pulse, or a rising edge against the registered history.
   always_comb begin
      live   = EDGE_DETECT ? (evt_in & ~prev_q) : evt_in;
      prev_d = evt_in;
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      pend_d = pend_q;
      if (drop) begin
         pend_d = 1'b0;
      end else if (take) begin
         pend_d = 1'b0;
      end else if (live && arm) begin
         pend_d = 1'b1;
      end
      evt_out = live | pend_q;
   end

   // History and pending flag registers.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
      if (!reset) begin
         prev_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/game_screen_sequencer.sv
// Game screen sequencer: tracks level/lives and commands the screen drawer
// with a one-cycle next pulse, waiting for the drawer to finish each redraw.
module game_screen_sequencer
   import game_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       miss,
   input  logic       level_clear,
   input  logic       draw_busy,
   output logic       next,
   output logic [3:0] next_screen,
   output logic [2:0] level,
   output logic [1:0] lives,
   output logic       busy
);

   localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   state_e          state_q, state_d;
   state_e          ret_q, ret_d;
   logic [2:0]      level_q, level_d;
   logic [1:0]      lives_q, lives_d;
   logic [3:0]      screen_q, screen_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic in_redraw;
   logic start_evt, miss_evt, lc_evt;
   logic take_start, take_miss, take_lc;
   logic clear_all, lc_drop;

   assign in_redraw = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);

   event_latch #(.EDGE_DETECT(1'b1)) u_start (
      .clock(clock), .reset(reset), .evt_in(start), .arm(in_redraw),
      .take(take_start), .drop(clear_all), .evt_out(start_evt)
   );

   event_latch #(.EDGE_DETECT(1'b0)) u_miss (
      .clock(clock), .reset(reset), .evt_in(miss), .arm(in_redraw || (state_q == ST_PLAY)),
      .take(take_miss), .drop(clear_all), .evt_out(miss_evt)
   );

   event_latch #(.EDGE_DETECT(1'b0)) u_level_clear (
      .clock(clock), .reset(reset), .evt_in(level_clear), .arm(in_redraw || (state_q == ST_PLAY)),
      .take(take_lc), .drop(clear_all || lc_drop), .evt_out(lc_evt)
   );

   // Next-state logic: game rules in the resting states, redraw handshake otherwise.
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      level_d    = level_q;
      lives_d    = lives_q;
      screen_d   = screen_q;
      cnt_d      = cnt_q;
      take_start = 1'b0;
      take_miss  = 1'b0;
      take_lc    = 1'b0;
      clear_all  = 1'b0;
      lc_drop    = 1'b0;
      case (state_q)
         ST_TITLE: begin
            if (start_evt) begin
               take_start = 1'b1;
               level_d    = 3'd1;
               lives_d    = LIVES_INIT;
               screen_d   = play_screen(3'd1, LIVES_INIT);
               ret_d      = ST_PLAY;
               state_d    = ST_ISSUE;
            end
         end
         ST_PLAY: begin
            // Miss wins over a simultaneous level_clear, which stays pending.
            if (miss_evt) begin
               take_miss = 1'b1;
               state_d   = ST_ISSUE;
               if (lives_q > 2'd1) begin
                  lives_d  = lives_q - 2'd1;
                  screen_d = play_screen(level_q, lives_q - 2'd1);
                  ret_d    = ST_PLAY;
               end else begin
                  level_d  = 3'd0;
                  lives_d  = 2'd0;
                  screen_d = SCR_LOSE;
                  ret_d    = ST_LOSE;
                  lc_drop  = 1'b1;
               end
            end else if (lc_evt) begin
               take_lc = 1'b1;
               state_d = ST_ISSUE;
               if (level_q < NUM_LEVELS) begin
                  level_d  = level_q + 3'd1;
                  screen_d = play_screen(level_q + 3'd1, lives_q);
                  ret_d    = ST_PLAY;
               end else begin
                  level_d  = 3'd0;
                  lives_d  = 2'd0;
                  screen_d = SCR_WIN;
                  ret_d    = ST_WIN;
               end
            end
         end
         ST_LOSE, ST_WIN: begin
            if (start_evt) begin
               take_start = 1'b1;
               screen_d   = SCR_START;
               ret_d      = ST_TITLE;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            // draw_busy may lag the next pulse, so it is ignored while settling.
            if (cnt_q < CW'(SETTLE_CYCLES)) begin
               cnt_d = cnt_q + 1'b1;
            end else if (!draw_busy) begin
               state_d   = ret_q;
               clear_all = (ret_q != ST_PLAY);
            end
         end
         default: state_d = ST_TITLE;
      endcase
   end

   // State, return-state and game registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_TITLE;
         ret_q    <= ST_TITLE;
         level_q  <= 3'd0;
         lives_q  <= 2'd0;
         screen_q <= SCR_START;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         level_q  <= level_d;
         lives_q  <= lives_d;
         screen_q <= screen_d;
         cnt_q    <= cnt_d;
      end
   end

   assign next        = (state_q == ST_ISSUE);
   assign busy        = in_redraw;
   assign next_screen = screen_q;
   assign level       = level_q;
   assign lives       = lives_q;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Directed, table-driven bench for game_screen_sequencer with a simple drawer model.
module tb_game_screen_sequencer;

   typedef enum int {OP_NONE, OP_START, OP_MISS, OP_LC, OP_BOTH, OP_HOLD} op_e;

   typedef struct {
      op_e        op;
      logic [3:0] scr;
      logic [2:0] lvl;
      logic [1:0] lf;
      int         draw;
      bit         dbl_miss;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       miss = 1'b0;
   logic       level_clear = 1'b0;
   logic       draw_busy = 1'b0;
   logic       next;
   logic [3:0] next_screen;
   logic [2:0] level;
   logic [1:0] lives;
   logic       busy;

   int passed = 0;
   int total  = 0;
   int next_cnt = 0;

   game_screen_sequencer #(.SETTLE_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .start(start), .miss(miss),
      .level_clear(level_clear), .draw_busy(draw_busy), .next(next),
      .next_screen(next_screen), .level(level), .lives(lives), .busy(busy)
   );

   always #5 clock = ~clock;

   // Count next pulses, sampled on the falling edge.
   always @(negedge clock) if (next) next_cnt <= next_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Apply one event, act as the drawer for the resulting redraw, check results.
   task automatic run_step(input int idx, input vec_t v);
      int  base;
      bit  found;
      bit  done;
      base = next_cnt;
      if (v.op == OP_HOLD) begin
         start = 1'b1;
         repeat (100) @(negedge clock);
         check($sformatf("v%0d hold nexts", idx), next_cnt - base, 1);
         check($sformatf("v%0d hold screen", idx), next_screen, v.scr);
         check($sformatf("v%0d hold level", idx), level, v.lvl);
         check($sformatf("v%0d hold lives", idx), lives, v.lf);
         check($sformatf("v%0d hold busy", idx), busy, 0);
         start = 1'b0;
         @(negedge clock);
         return;
      end
      start       = (v.op == OP_START);
      miss        = (v.op == OP_MISS) || (v.op == OP_BOTH);
      level_clear = (v.op == OP_LC) || (v.op == OP_BOTH);
      @(negedge clock);
      start = 1'b0; miss = 1'b0; level_clear = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (next) begin found = 1'b1; break; end
         @(negedge clock);
      end
      check($sformatf("v%0d next seen", idx), found, 1);
      check($sformatf("v%0d screen", idx), next_screen, v.scr);
      draw_busy = 1'b1;
      for (int k = 0; k < v.draw; k++) begin
         if (v.dbl_miss && k < 4) miss = (k == 0) || (k == 2);
         @(negedge clock);
      end
      miss = 1'b0;
      draw_busy = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!busy) begin done = 1'b1; break; end
         @(negedge clock);
      end
      check($sformatf("v%0d busy low", idx), done, 1);
      check($sformatf("v%0d level", idx), level, v.lvl);
      check($sformatf("v%0d lives", idx), lives, v.lf);
      check($sformatf("v%0d next count", idx), next_cnt - base, 1);
   endtask

   vec_t vecs[$];

   initial begin
      int  base;
      bit  found;
      vecs = '{
         '{OP_START, 4'd1,  3'd1, 2'd3, 19200, 1'b0},
         '{OP_MISS,  4'd2,  3'd1, 2'd2, 5, 1'b0},
         '{OP_MISS,  4'd3,  3'd1, 2'd1, 5, 1'b0},
         '{OP_MISS,  4'd13, 3'd0, 2'd0, 5, 1'b0},
         '{OP_START, 4'd0,  3'd0, 2'd0, 5, 1'b0},
         '{OP_START, 4'd1,  3'd1, 2'd3, 5, 1'b0},
         '{OP_LC,    4'd4,  3'd2, 2'd3, 5, 1'b0},
         '{OP_LC,    4'd7,  3'd3, 2'd3, 5, 1'b0},
         '{OP_LC,    4'd10, 3'd4, 2'd3, 5, 1'b0},
         '{OP_LC,    4'd14, 3'd0, 2'd0, 5, 1'b0},
         '{OP_HOLD,  4'd0,  3'd0, 2'd0, 0, 1'b0},
         '{OP_START, 4'd1,  3'd1, 2'd3, 5, 1'b0},
         '{OP_LC,    4'd4,  3'd2, 2'd3, 5, 1'b0},
         '{OP_BOTH,  4'd5,  3'd2, 2'd2, 5, 1'b0},
         '{OP_NONE,  4'd8,  3'd3, 2'd2, 5, 1'b0},
         '{OP_LC,    4'd11, 3'd4, 2'd2, 6, 1'b1},
         '{OP_NONE,  4'd12, 3'd4, 2'd1, 5, 1'b0}
      };

      // Reset state.
      #1;
      check("rst next", next, 0);
      check("rst screen", next_screen, 0);
      check("rst level", level, 0);
      check("rst lives", lives, 0);
      check("rst busy", busy, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("no next after reset", next_cnt, 0);

      // miss / level_clear are ignored in TITLE.
      miss = 1'b1; level_clear = 1'b1;
      @(negedge clock);
      miss = 1'b0; level_clear = 1'b0;
      repeat (10) @(negedge clock);
      check("title ignores events", next_cnt, 0);

      foreach (vecs[i]) run_step(i, vecs[i]);

      // Only one decrement from the double miss: no further redraw follows.
      base = next_cnt;
      repeat (10) @(negedge clock);
      check("dbl miss no extra next", next_cnt - base, 0);
      check("dbl miss lives", lives, 1);

      // Reset during WAIT_DONE abandons the redraw.
      miss = 1'b1;
      @(negedge clock);
      miss = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (next) begin found = 1'b1; break; end
         @(negedge clock);
      end
      check("lose next seen", found, 1);
      check("lose screen", next_screen, 13);
      draw_busy = 1'b1;
      repeat (2) @(negedge clock);
      check("mid redraw busy", busy, 1);
      reset = 1'b0;
      #1;
      check("async rst next", next, 0);
      check("async rst screen", next_screen, 0);
      check("async rst level", level, 0);
      check("async rst lives", lives, 0);
      check("async rst busy", busy, 0);
      base = next_cnt;
      @(negedge clock);
      reset = 1'b1;
      draw_busy = 1'b0;
      repeat (30) @(negedge clock);
      check("no next after mid reset", next_cnt - base, 0);
      check("idle busy after reset", busy, 0);
      run_step(100, '{OP_START, 4'd1, 3'd1, 2'd3, 5, 1'b0});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Absolute watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/game_screen_sequencer.md
GAME_SCREEN_SEQUENCER -- requirements
Module: game_screen_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, 2, cycles after a next pulse during which draw_busy is ignored.
REQ-002 clock  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  synchronous start/continue button, level-sensitive, active high.
REQ-005 miss  input  1  one-cycle pulse: wrong note played.
REQ-006 level_clear  input  1  one-cycle pulse: current level's song completed.
REQ-007 draw_busy  input  1  drawer enable; high while a screen is being painted.
REQ-008 next  output  1  one-cycle pulse commanding the drawer to paint next_screen.
REQ-009 next_screen  output  4  screen code; held stable from its next pulse until the following next pulse.
REQ-010 level  output  3  current level 1..4; 0 outside play.
REQ-011 lives  output  2  remaining lives 1..3; 0 outside play.
REQ-012 busy  output  1  high while in ISSUE or WAIT_DONE.

Function
REQ-013 Screen codes SHALL be: 0 start, 13 lose, 14 win; in play, code = 3*level + 1 - lives (level 1/lives 3 = 1, level 4/lives 1 = 12).
REQ-014 States SHALL be TITLE, PLAY, LOSE, WIN, ISSUE, WAIT_DONE; a return-state register records the destination of each redraw.
REQ-015 start_edge SHALL be start high with the registered previous start low; start held high produces exactly one edge.
REQ-016 ISSUE SHALL last exactly one cycle with next=1, next_screen already updated that cycle, then go to WAIT_DONE.
REQ-017 WAIT_DONE SHALL ignore draw_busy for SETTLE_CYCLES cycles, then leave for the return state on the first cycle draw_busy=0.
REQ-018 TITLE: start_edge -> level=1, lives=3, screen 1, return PLAY, go ISSUE.
REQ-019 PLAY, miss with lives>1 -> lives-1, screen recomputed, return PLAY, ISSUE.
REQ-020 PLAY, miss with lives=1 -> level=0, lives=0, screen 13, return LOSE, ISSUE.
REQ-021 PLAY, level_clear with level<4 -> level+1, lives unchanged, screen recomputed, return PLAY, ISSUE.
REQ-022 PLAY, level_clear with level=4 -> level=0, lives=0, screen 14, return WIN, ISSUE.
REQ-023 LOSE or WIN: start_edge -> screen 0, return TITLE, ISSUE.
REQ-024 miss, level_clear and start_edge arriving in ISSUE/WAIT_DONE SHALL set one-deep pending flags; repeats while pending are dropped; a pending flag is cleared the cycle its event is consumed.
REQ-025 In PLAY, live and pending events SHALL be treated identically; miss SHALL take priority over level_clear in the same cycle, with level_clear left pending.
REQ-026 A pending level_clear SHALL be discarded when a miss causes the LOSE transition.
REQ-027 start_edge SHALL be ignored in PLAY; miss/level_clear ignored in TITLE, LOSE, WIN; all pending flags cleared on entering TITLE, LOSE or WIN.
REQ-028 level and lives SHALL never wrap: no decrement below 1, no increment above 4.

Reset
REQ-029 Asserted reset SHALL immediately force state TITLE, next=0, next_screen=0, level=0, lives=0, busy=0, pending flags and start history cleared.
REQ-030 Reset SHALL issue no next pulse; the drawer paints screen 0 from its own reset.
REQ-031 Reset mid-redraw SHALL abandon the redraw with no further next pulse.

Structure
REQ-032 Shared package game_pkg SHALL hold the state enumeration, SCR_START=0, SCR_LOSE=13, SCR_WIN=14, LIVES_INIT=3, NUM_LEVELS=4.
REQ-033 One sub-module event_latch (edge detect plus one-deep pending flag) SHALL be instantiated per event input.

Verification
REQ-034 Reset, start pulse, draw_busy high 19200 cycles -> one next with next_screen=1, busy low after draw_busy falls, level=1, lives=3.
REQ-035 From level 1/lives 3: three misses, each after redraw -> screens 2, 3, 13; final level=0, lives=0, state LOSE.
REQ-036 Three level_clear then fourth level_clear -> screens 4, 7, 10, 14; WIN; start -> screen 0.
REQ-037 miss and level_clear same cycle at level 2/lives 3 -> screen 5, then after redraw screen 8.
REQ-038 Two misses during WAIT_DONE -> only one lives decrement after redraw; start held high 100 cycles -> single transition.
REQ-039 Reset asserted mid-WAIT_DONE -> all outputs 0 immediately, no next after release.
